// File: rtl/alu.sv
// 16-bit SimpleRISC ALU: combinational add/sub/and/not with a
// zero/negative/overflow condition vector and a registered status copy.
module alu (
   input  logic [15:0] Ain,
   input  logic [15:0] Bin,
   input  logic [1:0]  ALUop,
   output logic [15:0] out,
   output logic [2:0]  Z,
   input  logic        clk,
   input  logic        reset,
   input  logic        loads,
   output logic [2:0]  status
);

   logic [15:0] w_sum;
   logic [15:0] w_diff;
   logic        w_ovf;
   logic        zZTemp;
   logic [2:0]  r_status;

   assign w_sum  = Ain + Bin;
   assign w_diff = Ain + ~Bin + 16'd1;

   // Result select; an unknown opcode propagates X to the result.
   always_comb begin
      out   = '0;
      w_ovf = 1'b0;
      case (ALUop)
         2'b00: begin
            out   = w_sum;
            w_ovf = (Ain[15] == Bin[15]) && (w_sum[15] != Ain[15]);
         end
         2'b01: begin
            out   = w_diff;
            w_ovf = (Ain[15] != Bin[15]) && (w_diff[15] != Ain[15]);
         end
         2'b10:   out = Ain & Bin;
         2'b11:   out = ~Bin;
         default: out = 'x;
      endcase
   end

   assign zZTemp = (out == 16'h0000);
   assign Z      = {w_ovf, out[15], zZTemp};

   // Status register: reset dominates load, otherwise hold.
   always_ff @(posedge clk) begin
      if (reset)
         r_status <= '0;
      else if (loads)
         r_status <= Z;
   end

   assign status = r_status;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, status register
// sequencing and a random sweep against an integer reference model.
module tb_alu;

   logic [15:0] Ain, Bin, out;
   logic [1:0]  ALUop;
   logic [2:0]  Z, status;
   logic        clk, reset, loads;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   alu dut (
      .Ain    (Ain),
      .Bin    (Bin),
      .ALUop  (ALUop),
      .out    (out),
      .Z      (Z),
      .clk    (clk),
      .reset  (reset),
      .loads  (loads),
      .status (status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: signed integer arithmetic, overflow = result out of 16-bit range.
   function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic [1:0] op);
      int          sa, sb, s;
      logic [15:0] r;
      logic        v;
      sa = int'($signed(a));
      sb = int'($signed(b));
      v  = 1'b0;
      case (op)
         2'b00: begin s = sa + sb; r = s[15:0]; v = (s > 32767) || (s < -32768); end
         2'b01: begin s = sa - sb; r = s[15:0]; v = (s > 32767) || (s < -32768); end
         2'b10: r = a & b;
         default: r = ~b;
      endcase
      return {v, r[15], (r == 16'h0000), r};
   endfunction

   task automatic vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] op, input logic [15:0] eout, input logic [2:0] ez);
      Ain = a; Bin = b; ALUop = op;
      #2;
      check({tag, ".out"}, out, eout);
      check({tag, ".Z"}, {13'd0, Z}, {13'd0, ez});
      check({tag, ".zZTemp"}, {15'd0, dut.zZTemp}, {15'd0, ez[0]});
   endtask

   initial begin
      logic [18:0] m;
      reset = 1'b0; loads = 1'b0;
      Ain = '0; Bin = '0; ALUop = 2'b00;

      // Combinational results, no clock dependence required.
      #10;
      vec("add",  16'h000A, 16'h0001, 2'b00, 16'h000B, 3'b000);
      vec("sub",  16'h000A, 16'h0001, 2'b01, 16'h0009, 3'b000);
      vec("and",  16'h000A, 16'h0001, 2'b10, 16'h0000, 3'b001);
      vec("not",  16'h000A, 16'h0001, 2'b11, 16'hFFFE, 3'b010);
      vec("ovfp", 16'h7FFF, 16'h0001, 2'b00, 16'h8000, 3'b110);
      vec("ovfn", 16'h8000, 16'h0001, 2'b01, 16'h7FFF, 3'b100);
      vec("wrap", 16'hFFFF, 16'h0001, 2'b00, 16'h0000, 3'b001);
      vec("neg",  16'h0000, 16'h0001, 2'b01, 16'hFFFF, 3'b010);
      vec("subo", 16'h7FFF, 16'hFFFF, 2'b01, 16'h8000, 3'b110);
      vec("addn", 16'h8000, 16'h8000, 2'b00, 16'h0000, 3'b101);

      // Status register sequencing.
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("st.reset", {13'd0, status}, 16'd0);
      reset = 1'b0;
      Ain = 16'h8000; Bin = 16'h0001; ALUop = 2'b01; loads = 1'b1;
      @(negedge clk);
      check("st.load", {13'd0, status}, 16'd4);
      loads = 1'b0;
      Ain = 16'h0000; Bin = 16'h0000; ALUop = 2'b00;
      @(negedge clk);
      @(negedge clk);
      check("st.hold", {13'd0, status}, 16'd4);
      Ain = 16'h0000; Bin = 16'h0001; ALUop = 2'b01; loads = 1'b1;
      @(negedge clk);
      check("st.load2", {13'd0, status}, 16'd2);
      Ain = 16'h7FFF; Bin = 16'h0001; ALUop = 2'b00; reset = 1'b1; loads = 1'b1;
      @(negedge clk);
      check("st.rstprio", {13'd0, status}, 16'd0);
      reset = 1'b0; loads = 1'b0;

      // Random sweep against the reference model.
      for (int i = 0; i < 1000; i++) begin
         Ain   = 16'($urandom);
         Bin   = 16'($urandom);
         ALUop = 2'($urandom_range(0, 3));
         #2;
         m = model(Ain, Bin, ALUop);
         check("rnd.out", out, m[15:0]);
         check("rnd.Z", {13'd0, Z}, {13'd0, m[18:16]});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu.md
# alu

16-bit two-operand arithmetic/logic unit for the SimpleRISC datapath. It computes add, subtract, bitwise AND or bitwise NOT on two 16-bit operands combinationally, and produces a 3-bit condition vector (zero, negative, overflow) for the result. A synchronously reset status register captures the condition vector on request, to feed the controller's conditional branches.

## Interface
Parameters:
- none; the datapath width is fixed at 16 bits.

Ports (clock and reset listed first; declaration order is given below):
- clk  input  1  rising-edge clock; clocks only the status register.
- reset  input  1  synchronous, active-high; clears the status register.
- Ain  input  16  operand A.
- Bin  input  16  operand B.
- ALUop  input  2  operation select.
- out  output  16  combinational result.
- Z  output  3  combinational condition vector: Z[0] zero, Z[1] negative, Z[2] signed overflow.
- loads  input  1  status load enable.
- status  output  3  registered copy of Z.

Port declaration order: Ain, Bin, ALUop, out, Z, clk, reset, loads, status. Positional instantiation of the first five ports must work; clk, reset and loads may be left unconnected.

## Operation
ALUop selects the result:
- 00: out = Ain + Bin, modulo 2^16; carry-out is discarded.
- 01: out = Ain - Bin, computed as Ain + ~Bin + 1, modulo 2^16.
- 10: out = Ain & Bin.
- 11: out = ~Bin; Ain is ignored.

Condition vector Z:
- Z[0] = 1 when out == 16'h0000. It is driven from an internal 1-bit net named exactly zZTemp, which must exist at the top level of the module because the bench probes it hierarchically.
- Z[1] = out[15].
- Z[2], signed two's-complement overflow:
  - add: Ain[15] == Bin[15] and out[15] != Ain[15].
  - subtract: Ain[15] != Bin[15] and out[15] != Ain[15].
  - AND and NOT: always 0.

Status register:
- Rising clk with reset = 1: status <= 3'b000. reset takes priority over loads.
- Rising clk with reset = 0 and loads = 1: status <= Z.
- Otherwise status holds its value.

out and Z contain no state. They are pure functions of Ain, Bin and ALUop and are unaffected by clk, reset or loads. An ALUop containing X or Z bits yields out = X.

## Timing
- out, Z and zZTemp are combinational, with zero-cycle latency. They must settle within one propagation delay of any input change, without any clock edge.
- status has one cycle of latency: it reflects Z as sampled at the rising edge where loads = 1.
- Reset value of status: 3'b000. out and Z have no reset value; they follow their inputs during reset.
- Reset asserted in the same cycle as loads: status becomes 000.
- Boundary cases:
  - 16'h7FFF + 16'h0001 gives out = 16'h8000 and Z = 3'b110.
  - 16'h8000 - 16'h0001 gives out = 16'h7FFF and Z = 3'b100.
  - 16'hFFFF + 16'h0001 gives out = 16'h0000 and Z = 3'b001; the carry is ignored and no overflow is flagged.

## Test plan
- Ain = 16'h000A, Bin = 16'h0001, ALUop = 00, wait 10 time units with no clock -> out = 16'h000B, zZTemp = 0, Z = 3'b000.
- Same operands, ALUop = 01 -> out = 16'h0009, zZTemp = 0. Then ALUop = 10 -> out = 16'h0000, zZTemp = 1, Z = 3'b001. Then ALUop = 11 -> out = 16'hFFFE, zZTemp = 0, Z = 3'b010.
- Overflow cases:
  - 7FFF + 0001 -> Z = 110.
  - 8000 - 0001 -> Z = 100.
  - FFFF + 0001 -> out = 0000, Z = 001.
  - 0000 - 0001 -> out = FFFF, Z = 010.
- Status register:
  1. reset = 1 for one edge -> status = 000.
  2. Release reset, apply 8000 - 0001, loads = 1 for one edge -> status = 100.
  3. loads = 0, change operands -> status holds 100.
- reset = 1 and loads = 1 on the same edge, with Z nonzero -> status = 000.
- Random sweep of 1000 operand/opcode vectors against a reference model -> out and all three Z bits match on every vector.
